// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and register-file defaults, reused by the execute-stage
// operand muxes and the forwarding logic.
package cpu_pkg;
    localparam int unsigned DATA_W       = 64;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned ZERO_REG_IDX = NUM_REGS - 1;
    localparam int unsigned REG_ADDR_W   = $clog2(NUM_REGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;
endpackage

// File: rtl/reg_wr_decoder.sv
// Decodes (en, addr) into a one-hot per-register strobe; the hardwired-zero register
// and out-of-range addresses never get a strobe.
module reg_wr_decoder
    import cpu_pkg::*;
#(
    parameter int unsigned N        = NUM_REGS,
    parameter int unsigned ZERO_REG = N - 1
) (
    input  logic                 en,
    input  logic [$clog2(N)-1:0] addr,
    output logic [N-1:0]         onehot
);
    localparam int unsigned AW = $clog2(N);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            onehot[i] = en && (addr == AW'(i)) && (i != ZERO_REG);
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write architectural register file with same-cycle write bypass and a
// per-register busy scoreboard that raises stall on load-use hazards.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned W        = DATA_W,
    parameter int unsigned N        = NUM_REGS,
    parameter int unsigned ZERO_REG = N - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [$clog2(N)-1:0] rd_addr1,
    input  logic [$clog2(N)-1:0] rd_addr2,
    input  logic                 rd_used1,
    input  logic                 rd_used2,
    output logic [W-1:0]         rd_data1,
    output logic [W-1:0]         rd_data2,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_addr,
    input  logic [W-1:0]         wr_data,
    input  logic                 busy_set,
    input  logic [$clog2(N)-1:0] busy_addr,
    output logic                 stall,
    output logic [N-1:0]         busy_vec
);
    localparam int unsigned AW    = $clog2(N);
    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]     regs [N];
    logic [N-1:0]     busy;
    logic [N-1:0]     wr_onehot;
    logic [N-1:0]     set_onehot;

    logic [W-1:0]     reg_ext [DEPTH];
    logic [DEPTH-1:0] busy_ext;
    logic [DEPTH-1:0] wr_ext;
    logic             hz1;
    logic             hz2;

    reg_wr_decoder #(.N(N), .ZERO_REG(ZERO_REG)) u_wr_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_onehot)
    );

    reg_wr_decoder #(.N(N), .ZERO_REG(ZERO_REG)) u_busy_dec (
        .en     (busy_set),
        .addr   (busy_addr),
        .onehot (set_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_onehot[i]) begin
                    regs[i] <= wr_data;
                end
            end
            // Set is applied after clear so a newly issued load supersedes an older writeback.
            busy <= (busy & ~wr_onehot) | set_onehot;
        end
    end

    // Pad to a power-of-two table so out-of-range addresses read 0, never bypass and never stall.
    always_comb begin
        busy_ext = '0;
        wr_ext   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            reg_ext[i] = '0;
        end
        for (int unsigned i = 0; i < N; i++) begin
            reg_ext[i]  = regs[i];
            busy_ext[i] = busy[i];
            wr_ext[i]   = wr_onehot[i];
        end
    end

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (rst_n) begin
            rd_data1 = wr_ext[rd_addr1] ? wr_data : reg_ext[rd_addr1];
            rd_data2 = wr_ext[rd_addr2] ? wr_data : reg_ext[rd_addr2];
        end
    end

    always_comb begin
        hz1   = rd_used1 && busy_ext[rd_addr1] && !wr_ext[rd_addr1];
        hz2   = rd_used2 && busy_ext[rd_addr2] && !wr_ext[rd_addr2];
        stall = rst_n && (hz1 || hz2);
    end

    assign busy_vec = busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic
// checked against an array-based architectural model.
module tb_regfile_scoreboard;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, busy_addr;
    logic        rd_used1, rd_used2, wr_en, busy_set;
    logic [63:0] rd_data1, rd_data2, wr_data;
    logic        stall;
    logic [31:0] busy_vec;

    int passed = 0;
    int total  = 0;

    logic [63:0] m_regs [32];
    bit          m_busy [32];

    regfile_scoreboard #(.W(64), .N(32), .ZERO_REG(31)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_used1  (rd_used1),
        .rd_used2  (rd_used2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .stall     (stall),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        logic h1, h2;
        h1 = rd_used1 && rd_addr1 != 5'd31 && m_busy[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
        h2 = rd_used2 && rd_addr2 != 5'd31 && m_busy[rd_addr2] && !(wr_en && wr_addr == rd_addr2);
        return h1 || h2;
    endfunction

    function automatic logic [31:0] exp_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (wr_en && wr_addr != 5'd31) m_regs[wr_addr] = wr_data;
        if (wr_en) m_busy[wr_addr] = 1'b0;
        if (busy_set && busy_addr != 5'd31) m_busy[busy_addr] = 1'b1;
    endtask

    task automatic idle();
        rd_addr1 = 5'd0; rd_addr2 = 5'd0; rd_used1 = 1'b0; rd_used2 = 1'b0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 64'd0;
        busy_set = 1'b0; busy_addr = 5'd0;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        // write + bypass attempt while held in reset: must read 0 and be discarded at the edge
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hAAAA_5555_AAAA_5555; rd_addr1 = 5'd5;
        busy_set = 1'b1; busy_addr = 5'd6; rd_addr2 = 5'd6; rd_used2 = 1'b1;
        #1;
        total++;
        if (rd_data1 !== 64'd0) $display("FAIL reset_bypass_gated rd_data1=%h exp=0", rd_data1);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (busy_vec !== 32'd0 || stall !== 1'b0)
            $display("FAIL reset_hold busy_vec=%h stall=%b exp=0/0", busy_vec, stall);
        else passed++;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a); rd_used1 = 1'b1; rd_used2 = 1'b1;
            #1;
            total++;
            if (rd_data1 !== 64'd0 || rd_data2 !== 64'd0 || stall !== 1'b0 || busy_vec !== 32'd0)
                $display("FAIL reset_read a=%0d d1=%h d2=%h stall=%b busy=%h exp=0", a, rd_data1, rd_data2, stall, busy_vec);
            else passed++;
        end
        idle();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0123_4567;
        clock_edge();
        idle();
        rd_addr1 = 5'd5;
        #1;
        total++;
        if (rd_data1 !== 64'hDEAD_BEEF_0123_4567)
            $display("FAIL write_read_x5 rd_data1=%h exp=deadbeef01234567", rd_data1);
        else passed++;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1; rd_addr2 = 5'd31;
        #1;
        total++;
        if (rd_data2 !== 64'd0) $display("FAIL x31_no_bypass rd_data2=%h exp=0", rd_data2);
        else passed++;
        clock_edge();
        idle();
        rd_addr1 = 5'd31;
        #1;
        total++;
        if (rd_data1 !== 64'd0) $display("FAIL x31_zero rd_data1=%h exp=0", rd_data1);
        else passed++;
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h42; rd_addr2 = 5'd7; rd_addr1 = 5'd7;
        #1;
        total++;
        if (rd_data2 !== 64'h42 || rd_data1 !== 64'h42)
            $display("FAIL bypass d1=%h d2=%h exp=42", rd_data1, rd_data2);
        else passed++;
        clock_edge();
        idle();
        rd_addr2 = 5'd7;
        #1;
        total++;
        if (rd_data2 !== 64'h42) $display("FAIL bypass_stored rd_data2=%h exp=42", rd_data2);
        else passed++;
    endtask

    task automatic test_stall();
        idle();
        busy_set = 1'b1; busy_addr = 5'd9;
        clock_edge();
        idle();
        rd_addr1 = 5'd9; rd_used1 = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1 || busy_vec[9] !== 1'b1)
            $display("FAIL load_use_stall stall=%b busy9=%b exp=1/1", stall, busy_vec[9]);
        else passed++;
        rd_used1 = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) $display("FAIL unused_no_stall stall=%b exp=0", stall);
        else passed++;
        rd_used1 = 1'b1; rd_addr2 = 5'd9; rd_used2 = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h10;
        #1;
        total++;
        if (stall !== 1'b0 || rd_data1 !== 64'h10)
            $display("FAIL writeback_resolves stall=%b rd_data1=%h exp=0/10", stall, rd_data1);
        else passed++;
        clock_edge();
        idle();
        rd_addr1 = 5'd9; rd_used1 = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0 || busy_vec[9] !== 1'b0 || rd_data1 !== 64'h10)
            $display("FAIL busy_cleared stall=%b busy9=%b d1=%h exp=0/0/10", stall, busy_vec[9], rd_data1);
        else passed++;
    endtask

    task automatic test_collision();
        idle();
        busy_set = 1'b1; busy_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h77;
        clock_edge();
        idle();
        #1;
        total++;
        if (busy_vec[3] !== 1'b1) $display("FAIL set_wins busy3=%b exp=1", busy_vec[3]);
        else passed++;
        busy_set = 1'b1; busy_addr = 5'd31;
        clock_edge();
        idle();
        rd_addr2 = 5'd31; rd_used2 = 1'b1;
        #1;
        total++;
        if (busy_vec !== exp_busy_vec() || busy_vec[31] !== 1'b0 || stall !== 1'b0)
            $display("FAIL busy_x31 busy_vec=%h stall=%b exp=%h/0", busy_vec, stall, exp_busy_vec());
        else passed++;
    endtask

    task automatic test_async_reset();
        idle();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h99;
        busy_set = 1'b1; busy_addr = 5'd4;
        clock_edge();
        idle();
        rd_addr1 = 5'd2; rd_addr2 = 5'd4; rd_used2 = 1'b1;
        #1;
        total++;
        if (rd_data1 !== 64'h99 || busy_vec[4] !== 1'b1 || stall !== 1'b1)
            $display("FAIL pre_reset_state d1=%h busy4=%b stall=%b exp=99/1/1", rd_data1, busy_vec[4], stall);
        else passed++;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (rd_data1 !== 64'd0 || busy_vec !== 32'd0 || stall !== 1'b0)
            $display("FAIL async_reset d1=%h busy=%h stall=%b exp=0", rd_data1, busy_vec, stall);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (rd_data1 !== 64'd0 || busy_vec !== 32'd0)
            $display("FAIL after_reset_release d1=%h busy=%h exp=0", rd_data1, busy_vec);
        else passed++;
        idle();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            logic [63:0] e1, e2;
            logic        es;
            rd_addr1  = 5'($urandom_range(0, 31));
            rd_addr2  = ($urandom_range(0, 3) == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
            rd_used1  = 1'($urandom_range(0, 1));
            rd_used2  = 1'($urandom_range(0, 1));
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = ($urandom_range(0, 2) == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
            wr_data   = {$urandom, $urandom};
            busy_set  = ($urandom_range(0, 2) == 0);
            busy_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(rd_addr1);
            e2 = exp_rd(rd_addr2);
            es = exp_stall();
            total++;
            if (rd_data1 !== e1 || rd_data2 !== e2 || stall !== es || busy_vec !== exp_busy_vec()) begin
                if (errs < 10)
                    $display("FAIL random n=%0d d1=%h/%h d2=%h/%h stall=%b/%b busy=%h/%h (got/exp)",
                             n, rd_data1, e1, rd_data2, e2, stall, es, busy_vec, exp_busy_vec());
                errs++;
            end else passed++;
            clock_edge();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_collision();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exp=finish");
        $fatal(1);
    end
endmodule
